// File: rtl/lut_neuron_pipe.sv
// Runtime-programmable LUT neuron: zero-cleared distributed-RAM truth table with
// a config write port and a 2-stage valid/ready lookup pipeline.
module lut_neuron_pipe #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    input  logic                cfg_we,
    input  logic [IN_BITS-1:0]  cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_ready,
    output logic                init_done
);

    localparam int unsigned DEPTH = 2 ** IN_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [IN_BITS-1:0]  cnt;
    logic [IN_BITS-1:0]  a1;
    logic                v1;
    logic                v2;
    logic [OUT_BITS-1:0] d2;
    logic [OUT_BITS-1:0] tbl [DEPTH];

    logic                run;
    logic                load1;
    logic                load2;
    logic                wr_en;
    logic [IN_BITS-1:0]  wr_addr;
    logic [OUT_BITS-1:0] wr_data;

    assign run       = (state == RUN) & ~rst;
    assign load2     = ~v2 | out_ready;
    assign load1     = ~v1 | load2;
    assign in_ready  = run & load1;
    assign cfg_ready = run;
    assign init_done = run;
    assign out_valid = v2 & ~rst;
    assign out_data  = rst ? '0 : d2;

    // The clear sweep owns the single write port during INIT; config only in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt;
        wr_data = '0;
        if (!rst) begin
            if (state == INIT) begin
                wr_en = 1'b1;
            end else if (cfg_we) begin
                wr_en   = 1'b1;
                wr_addr = cfg_addr;
                wr_data = cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            d2    <= '0;
        end else begin
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == '1) begin
                    state <= RUN;
                end
            end
            if (load1) begin
                a1 <= in_data;
                v1 <= in_valid & in_ready;
            end
            // Non-blocking table write: a same-edge write is not seen here.
            if (load2) begin
                d2 <= tbl[a1];
                v2 <= v1;
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Directed bench for lut_neuron_pipe: default instance (8/2) plus a 4/6 corner
// instance sharing clock and reset.
module tb_lut_neuron_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, cfg_addr;
    logic [1:0] out_data, cfg_data;
    logic       cfg_we, cfg_ready, init_done;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_in_data, b_cfg_addr;
    logic [5:0] b_out_data, b_cfg_data;
    logic       b_cfg_we, b_cfg_ready, b_init_done;

    lut_neuron_pipe #(.IN_BITS(8), .OUT_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .init_done(init_done)
    );

    lut_neuron_pipe #(.IN_BITS(4), .OUT_BITS(6)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .cfg_ready(b_cfg_ready), .init_done(b_init_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic       acc;
    logic [1:0] rq[$];
    logic [1:0] r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, return 1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc = in_valid & in_ready;
        if (out_valid & out_ready) rq.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] a, output logic [1:0] res);
        rq.delete();
        out_ready = 1'b1; in_valid = 1'b1; in_data = a;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5 && rq.size() == 0; j++) tick();
        if (rq.size() == 0) begin
            chk("lookup_timeout", 32'(rq.size()), 32'd1);
            res = 'x;
        end else begin
            res = rq[0];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int bad, stall, errs, n;
        in_valid = 0; in_data = '0; out_ready = 1; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_cfg_we = 0; b_cfg_addr = '0; b_cfg_data = '0;

        tick(); tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b0;

        // Reset sweep, with a config write attempted during INIT.
        bad = 0;
        for (int i = 1; i <= 256; i++) begin
            if (i == 10) begin cfg_we = 1; cfg_addr = 8'd5; cfg_data = 2'd3; end
            tick();
            cfg_we = 0;
            if (i < 256 && (in_ready | cfg_ready | out_valid | init_done)) bad++;
            if (i == 15)  chk("b_init_15", 32'(b_init_done), 32'd0);
            if (i == 16)  chk("b_init_16", 32'(b_init_done), 32'd1);
            if (i == 255) chk("init_255",  32'(init_done),   32'd0);
        end
        chk("init_256",    32'(init_done), 32'd1);
        chk("cfg_ready",   32'(cfg_ready), 32'd1);
        chk("in_ready",    32'(in_ready),  32'd1);
        chk("init_quiet",  32'(bad),       32'd0);
        lookup(8'd5, r);
        chk("cfg_in_init_ignored", 32'(r), 32'd0);

        // Program table[k] = k[1:0], then stream 0..255.
        for (int k = 0; k < 256; k++) cfg_write(8'(k), 2'(k % 4));
        rq.delete();
        stall = 0;
        for (int k = 0; k < 256; k++) begin
            in_valid = 1; in_data = 8'(k);
            tick();
            if (!acc) stall++;
            if (k == 0) chk("lat_edge1", 32'(out_valid), 32'd0);
            if (k == 1) chk("lat_edge2", 32'(out_valid), 32'd1);
        end
        in_valid = 0;
        chk("stream_no_stall", 32'(stall), 32'd0);
        chk("stream_rate", 32'(rq.size()), 32'd254);
        tick(); tick();
        chk("stream_count", 32'(rq.size()), 32'd256);
        errs = 0;
        for (int i = 0; i < rq.size(); i++) if (rq[i] !== 2'(i % 4)) errs++;
        chk("stream_data_errs", 32'(errs), 32'd0);

        // Backpressure with three requests.
        cfg_write(8'h10, 2'd3);
        rq.delete();
        out_ready = 0; in_valid = 1; in_data = 8'h10;
        tick(); chk("bp_acc0", 32'(acc), 32'd1);
        in_data = 8'h11;
        tick(); chk("bp_acc1", 32'(acc), 32'd1);
        in_data = 8'h12;
        #1 chk("bp_full_rdy", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("bp_hold_acc", 32'(acc),       32'd0);
        chk("bp_ov",       32'(out_valid), 32'd1);
        chk("bp_od",       32'(out_data),  32'd3);
        out_ready = 1;
        #1 chk("bp_release_rdy", 32'(in_ready), 32'd1);
        for (int j = 0; j < 6; j++) begin
            tick();
            if (acc) in_valid = 0;
        end
        chk("bp_count", 32'(rq.size()), 32'd3);
        if (rq.size() >= 3) chk("bp_order", 32'({rq[0], rq[1], rq[2]}), 32'b11_01_10);

        // Read-before-write at the stage-2 capture edge.
        cfg_write(8'h2A, 2'd1);
        rq.delete();
        out_ready = 1; in_valid = 1; in_data = 8'h2A;
        tick(); chk("rbw_acc", 32'(acc), 32'd1);
        in_valid = 0;
        cfg_we = 1; cfg_addr = 8'h2A; cfg_data = 2'd3;
        tick();
        cfg_we = 0;
        chk("rbw_ov",  32'(out_valid), 32'd1);
        chk("rbw_old", 32'(out_data),  32'd1);
        tick();
        lookup(8'h2A, r);
        chk("rbw_new", 32'(r), 32'd3);

        // A request held in stage 1 across a write sees the new value.
        out_ready = 0; in_valid = 1; in_data = 8'h00;
        tick();
        in_data = 8'h2A;
        tick();
        in_valid = 0;
        cfg_write(8'h2A, 2'd2);
        rq.delete();
        out_ready = 1;
        tick(); tick(); tick();
        chk("held_count", 32'(rq.size()), 32'd2);
        if (rq.size() >= 2) chk("held_new", 32'(rq[1]), 32'd2);

        // Corner instance: IN_BITS=4, OUT_BITS=6.
        chk("b_cfg_ready", 32'(b_cfg_ready), 32'd1);
        b_cfg_we = 1; b_cfg_addr = 4'd15; b_cfg_data = 6'h3F;
        tick();
        b_cfg_we = 0;
        b_in_valid = 1; b_in_data = 4'd15;
        #1 chk("b_in_ready", 32'(b_in_ready), 32'd1);
        tick();
        b_in_data = 4'd14;
        tick();
        b_in_valid = 0;
        chk("b_ov15", 32'(b_out_valid), 32'd1);
        chk("b_od15", 32'(b_out_data),  32'h3F);
        tick();
        chk("b_od14", 32'(b_out_data),  32'h00);

        // Mid-stream reset with both stages full.
        out_ready = 0; in_valid = 1; in_data = 8'h2A;
        tick();
        in_data = 8'h01;
        tick();
        in_valid = 0;
        chk("mr_full_ov",  32'(out_valid), 32'd1);
        chk("mr_full_rdy", 32'(in_ready),  32'd0);
        rst = 1;
        tick();
        rst = 0;
        rq.delete();
        chk("mr_ov",   32'(out_valid), 32'd0);
        chk("mr_init", 32'(init_done), 32'd0);
        out_ready = 1;
        n = 0;
        while (!init_done && n < 300) begin
            tick();
            n++;
        end
        chk("mr_sweep_len", 32'(n), 32'd256);
        chk("mr_no_stale",  32'(rq.size()), 32'd0);
        lookup(8'h2A, r);
        chk("mr_zero_2a", 32'(r), 32'd0);
        lookup(8'h01, r);
        chk("mr_zero_01", 32'(r), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
